// File: rtl/lsu_pkg.sv
// Shared load/store-unit types: memory size and exception cause encodings,
// the issued load op, the load-queue enqueue payload and the AGU S2 payload.
package lsu_pkg;

    localparam int LSU_ADDR_W = 32;
    localparam int LSU_ROB_W  = 6;
    localparam int LSU_IMM_W  = 12;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_ILLEGAL  = 2'b10
    } exc_cause_e;

    typedef struct packed {
        logic [LSU_ROB_W-1:0]  rob;
        logic [LSU_ADDR_W-1:0] base;
        logic [LSU_IMM_W-1:0]  imm;
        mem_size_e             size;
        logic                  sext;
    } agu_op_t;

    typedef struct packed {
        logic [LSU_ROB_W-1:0]  rob;
        logic [LSU_ADDR_W-1:0] addr;
        mem_size_e             size;
        logic                  sext;
    } lq_enq_t;

    // S2 holds the enqueue payload plus the fault verdict for it.
    typedef struct packed {
        lq_enq_t    enq;
        exc_cause_e cause;
    } agu_s2_t;

    // Illegal size outranks misalignment; bytes never misalign.
    function automatic exc_cause_e fault_check(input mem_size_e size, input logic [1:0] addr_lo);
        exc_cause_e c;
        c = EXC_NONE;
        if (size == SZ_ILL)
            c = EXC_ILLEGAL;
        else if (size == SZ_WORD && addr_lo != 2'b00)
            c = EXC_MISALIGN;
        else if (size == SZ_HALF && addr_lo[0])
            c = EXC_MISALIGN;
        return c;
    endfunction

endpackage

// File: rtl/agu_pipe_stage.sv
// Generic single-entry valid/ready register stage with flush.
// Accepts when empty or when the current entry leaves this cycle.
module agu_pipe_stage
    import lsu_pkg::*;
#(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic valid_q, valid_d;
    T     data_q,  data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Next state: flush empties the stage and drops whatever is offered.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i)
                data_d = in_data_i;
        end
    end

    // Stage register; payload is zeroed by reset so idle outputs read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/load_agu.sv
// Load address-generation unit: S1 registers the issued op, the effective
// address and fault check are computed between S1 and S2, S2 either enqueues
// into the load queue or raises a one-cycle exception to the ROB.
module load_agu
    import lsu_pkg::*;
#(
    // Widths must match the lsu_pkg struct fields.
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int ROB_W  = LSU_ROB_W,
    parameter int IMM_W  = LSU_IMM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROB_W-1:0]  in_rob,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [1:0]        in_size,
    input  logic              in_sext,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROB_W-1:0]  out_rob,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_size,
    output logic              out_sext,
    output logic              exc_valid,
    output logic [ROB_W-1:0]  exc_rob,
    output logic [1:0]        exc_cause,
    output logic [ADDR_W-1:0] exc_addr
);

    agu_op_t     op_in, s1_op;
    agu_s2_t     s2_in, s2_q;
    logic        s1_valid, s1_ready;
    logic        s2_valid, s2_ready, s2_fire, s2_fault;
    logic [ADDR_W-1:0] ea;

    // Pack the issue port into an op.
    always_comb begin
        op_in      = '0;
        op_in.rob  = in_rob;
        op_in.base = in_base;
        op_in.imm  = in_imm;
        op_in.size = mem_size_e'(in_size);
        op_in.sext = in_sext;
    end

    agu_pipe_stage #(.T(agu_op_t)) u_s1 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (s1_ready),
        .in_data_i   (op_in),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .out_data_o  (s1_op)
    );

    // Effective address (carry out dropped) and fault verdict for S2.
    always_comb begin
        ea             = s1_op.base + {{(ADDR_W-IMM_W){s1_op.imm[IMM_W-1]}}, s1_op.imm};
        s2_in          = '0;
        s2_in.enq.rob  = s1_op.rob;
        s2_in.enq.addr = ea;
        s2_in.enq.size = s1_op.size;
        s2_in.enq.sext = s1_op.sext;
        s2_in.cause    = fault_check(s1_op.size, ea[1:0]);
    end

    // A faulting op leaves S2 after its single exception cycle, whatever
    // the load queue is doing; a good op leaves only on a real enqueue.
    assign s2_fault = s2_q.cause != EXC_NONE;
    assign s2_fire  = s2_valid && (s2_fault || out_ready);

    agu_pipe_stage #(.T(agu_s2_t)) u_s2 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .in_data_i   (s2_in),
        .out_valid_o (s2_valid),
        .out_ready_i (s2_fire),
        .out_data_o  (s2_q)
    );

    // Handshakes are suppressed during reset and flush so nothing is
    // accepted, enqueued or reported in those cycles.
    assign in_ready  = !rst && !flush && s1_ready;
    assign out_valid = !rst && !flush && s2_valid && !s2_fault;
    assign exc_valid = !rst && !flush && s2_valid &&  s2_fault;

    assign out_rob   = s2_q.enq.rob;
    assign out_addr  = s2_q.enq.addr;
    assign out_size  = s2_q.enq.size;
    assign out_sext  = s2_q.enq.sext;
    assign exc_rob   = s2_q.enq.rob;
    assign exc_addr  = s2_q.enq.addr;
    assign exc_cause = s2_q.cause;

endmodule
